// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue between the I-cache and the IF stage.
// Issues one block-aligned fetch at a time, writes each returned block in a
// single cycle and hands instructions to IF one per cycle with their PC.
// Redirects flush the queue, drain a stale in-flight response and skip the
// leading words of a misaligned target block.
// Optional: define IFPQ_STATS_EN to add stall/drop statistics counters.
//
// Handshakes: a request transfers on a cycle where mem_req_valid && mem_req_ready;
// mem_req_valid/mem_req_addr stay stable until then. A head instruction is
// consumed on a cycle where instr_valid && instr_ready. mem_rsp_valid is a
// single-cycle beat with no back-pressure, one beat per accepted request.
module ifetch_prefetch_queue #(
  parameter int INSTR_W   = 32,
  parameter int BURST_N   = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int LOW_WATER = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic                          instr_ready,
  output logic                          instr_valid,
  output logic [INSTR_W-1:0]            instr_data,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [BURST_N*INSTR_W-1:0]    mem_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]    fill_level,
  output logic [1:0]                    dbg_state
`ifdef IFPQ_STATS_EN
  ,
  output logic [31:0]                   stat_stall_cycles,
  output logic [15:0]                   stat_drops
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int IB  = INSTR_W / 8;
  localparam int BLK = BURST_N * IB;
  localparam int BO  = $clog2(IB);
  localparam int BB  = $clog2(BLK);
  localparam int SW  = $clog2(BURST_N);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [INSTR_W-1:0]  data_mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [PW-1:0]       w_ptr_q, r_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [ADDR_W-1:0]   rsp_base_q;
  logic [SW-1:0]       skip_q;
  logic                started_q;
  logic                req_valid_q;

  logic                hs;
  logic                pop;
  logic                wr_en;
  logic [CW-1:0]       wr_cnt;
  logic                has_space;

  assign hs        = req_valid_q && mem_req_ready;
  assign pop       = instr_valid && instr_ready;
  // A response in a redirect cycle belongs to the old stream and is ignored.
  assign wr_en     = (state_q == S_WAIT) && mem_rsp_valid && !redirect_valid;
  assign wr_cnt    = CW'(BURST_N) - CW'(skip_q);
  assign has_space = (int'(count_q) + BURST_N <= DEPTH) && (int'(count_q) <= LOW_WATER);

  assign instr_valid   = (count_q != '0);
  assign instr_data    = data_mem_q[r_ptr_q];
  assign instr_pc      = pc_mem_q[r_ptr_q];
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign fill_level    = count_q;
  assign dbg_state     = state_q;

  // Next occupancy: a write and a pop in the same cycle net out.
  always_comb begin
    count_d = count_q;
    if (wr_en) count_d = count_d + wr_cnt;
    if (pop)   count_d = count_d - CW'(1);
  end

  // Control FSM, pointers, occupancy and fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      fetch_pc_q  <= '0;
      rsp_base_q  <= '0;
      skip_q      <= '0;
      started_q   <= 1'b0;
    end else if (redirect_valid) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      fetch_pc_q  <= redirect_pc & ~BLK_MASK;
      skip_q      <= redirect_pc[BB-1:BO];
      started_q   <= 1'b1;
      req_valid_q <= 1'b0;
      // Any request already accepted by the cache still owes us a beat.
      case (state_q)
        S_WAIT, S_DRAIN: state_q <= S_DRAIN;
        S_REQ:           state_q <= hs ? S_DRAIN : S_IDLE;
        default:         state_q <= S_IDLE;
      endcase
    end else begin
      count_q <= count_d;
      if (pop) r_ptr_q <= r_ptr_q + PW'(1);
      if (wr_en) begin
        w_ptr_q <= w_ptr_q + PW'(wr_cnt);
        skip_q  <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (started_q && has_space) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            rsp_base_q  <= fetch_pc_q;
            fetch_pc_q  <= fetch_pc_q + ADDR_W'(BLK);
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (mem_rsp_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Block write: words skip..BURST_N-1 land contiguously from the write pointer.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int k = 0; k < BURST_N; k++) begin
        if (k >= int'(skip_q)) begin
          data_mem_q[PW'(w_ptr_q + PW'(k) - PW'(skip_q))] <= mem_rsp_data[k*INSTR_W +: INSTR_W];
          pc_mem_q[PW'(w_ptr_q + PW'(k) - PW'(skip_q))]   <= rsp_base_q + ADDR_W'(k * IB);
        end
      end
    end
  end

`ifdef IFPQ_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] drops_q;

  assign stat_stall_cycles = stall_q;
  assign stat_drops        = drops_q;

  // Saturating statistics; they survive redirects and clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      if (instr_ready && !instr_valid && started_q && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if ((state_q == S_DRAIN) && mem_rsp_valid && !redirect_valid && (drops_q != '1))
        drops_q <= drops_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Randomized bench for ifetch_prefetch_queue. A behavioural cache answers
// each accepted request after 1..4 cycles; a reference model tracks the
// expected instruction stream as a queue of PCs and the expected fetch
// addresses, and every sampled output is compared against it.
module tb_ifetch_prefetch_queue;

  localparam int INSTR_W   = 32;
  localparam int BURST_N   = 4;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 32;
  localparam int LOW_WATER = 8;
  localparam int IB        = INSTR_W / 8;
  localparam int BLK       = BURST_N * IB;
  localparam int NCYC      = 4000;

  // ---------------- clock / reset / DUT ----------------
  logic                         clk = 1'b0;
  logic                         reset;
  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic                         instr_ready;
  logic                         instr_valid;
  logic [INSTR_W-1:0]           instr_data;
  logic [ADDR_W-1:0]            instr_pc;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [ADDR_W-1:0]            mem_req_addr;
  logic                         mem_rsp_valid;
  logic [BURST_N*INSTR_W-1:0]   mem_rsp_data;
  logic [$clog2(DEPTH+1)-1:0]   fill_level;
  logic [1:0]                   dbg_state;
`ifdef IFPQ_STATS_EN
  logic [31:0]                  stat_stall_cycles;
  logic [15:0]                  stat_drops;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch_queue #(
    .INSTR_W(INSTR_W), .BURST_N(BURST_N), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .LOW_WATER(LOW_WATER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fill_level(fill_level),
    .dbg_state(dbg_state)
`ifdef IFPQ_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_drops(stat_drops)
`endif
  );

  // ---------------- scoreboard / reference model state ----------------
  int                n_vec = 0;
  int                n_err = 0;
  int                n_pop = 0;
  logic [ADDR_W-1:0] exp_q[$];      // PCs expected at the IF side, in order
  logic [ADDR_W-1:0] mreq_exp;      // next expected request address
  int                mskip;
  bit                started;
  bit                outstanding;   // cache owes one response beat
  int                rsp_left;
  int                rsp_epoch;
  int                epoch = 0;
  logic [ADDR_W-1:0] rsp_base;
  int                streak = 0;
  bit                rst_armed = 0;
  bit                rst_seen = 0;
  int                quiet_until = 0;

  // Instruction content is a fixed function of its address.
  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] pc);
    return INSTR_W'((pc * 32'h9E3779B1) ^ (pc >> 3));
  endfunction

  function automatic logic [BURST_N*INSTR_W-1:0] block_of(input logic [ADDR_W-1:0] base);
    logic [BURST_N*INSTR_W-1:0] b;
    for (int i = 0; i < BURST_N; i++) b[i*INSTR_W +: INSTR_W] = word_of(base + ADDR_W'(i * IB));
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mreq_exp    = '0;
    mskip       = 0;
    started     = 0;
    outstanding = 0;
    rsp_left    = 0;
    streak      = 0;
    epoch++;
  endtask

  // ---------------- driver: inputs for one cycle ----------------
  task automatic drive_cycle(input int c);
    reset          = (c < 3);
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    if (outstanding) begin
      rsp_left--;
      if (rsp_left == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = block_of(rsp_base);
      end
    end else if (c >= 3 && $urandom_range(0, 99) < 3) begin
      // Unsolicited beat while nothing is in flight: must be ignored.
      mem_rsp_valid = 1'b1;
      for (int i = 0; i < BURST_N; i++) mem_rsp_data[i*INSTR_W +: INSTR_W] = INSTR_W'($urandom);
    end
    if (rst_armed && outstanding && mem_rsp_valid) begin
      reset       = 1'b1;
      rst_armed   = 0;
      rst_seen    = 1;
      quiet_until = c + 12;
    end
    if (c < 60)                  instr_ready = 1'b0;
    else if (((c / 300) % 4) == 3) instr_ready = 1'b0;
    else                         instr_ready = ($urandom_range(0, 99) < 80);
    mem_req_ready = ($urandom_range(0, 99) < 70);
    if (c == 5) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10C;
    end else if (c >= 60 && c > quiet_until && !mem_rsp_valid && !reset &&
                 $urandom_range(0, 99) < 3) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100 + ADDR_W'($urandom_range(0, 511) << 2);
    end
  endtask

  // ---------------- compare outputs, then advance the model ----------------
  task automatic check_and_model();
    bit                hs, pop, rsp_done, wr, eligible;
    logic [ADDR_W-1:0] wr_base;
    if (reset) begin
      model_reset();
      return;
    end
    check("fill_level", 64'(fill_level), 64'(exp_q.size()));
    check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0 && instr_valid) begin
      check("instr_pc", 64'(instr_pc), 64'(exp_q[0]));
      check("instr_data", 64'(instr_data), 64'(word_of(exp_q[0])));
    end
    if (!started) begin
      check("idle_req_valid", 64'(mem_req_valid), 64'd0);
      check("idle_req_addr", 64'(mem_req_addr), 64'd0);
    end
    if (mem_req_valid)
      check("req_allowed", 64'(started && !outstanding && exp_q.size() <= LOW_WATER), 64'd1);
    eligible = started && !outstanding && (exp_q.size() <= LOW_WATER);
    if (eligible && !mem_req_valid) streak++; else streak = 0;
    if (streak > 2) begin
      check("req_liveness", 64'(streak), 64'd2);
      streak = 0;
    end
    if (redirect_valid) streak = 0;

    hs       = mem_req_valid && mem_req_ready;
    pop      = instr_valid && instr_ready;
    rsp_done = mem_rsp_valid && outstanding;
    wr       = rsp_done && (rsp_epoch == epoch) && !redirect_valid;
    wr_base  = rsp_base;
    if (hs) check("req_addr", 64'(mem_req_addr), 64'(mreq_exp));
    if (rsp_done) outstanding = 0;
    if (hs) begin
      outstanding = 1;
      rsp_epoch   = epoch;
      rsp_base    = mem_req_addr;
      rsp_left    = $urandom_range(1, 4);
    end
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      started  = 1;
      mskip    = int'(redirect_pc % BLK) / IB;
      mreq_exp = redirect_pc & ~ADDR_W'(BLK - 1);
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (wr) begin
        for (int k = mskip; k < BURST_N; k++) exp_q.push_back(wr_base + ADDR_W'(k * IB));
        mskip = 0;
      end
      if (hs) mreq_exp = mreq_exp + ADDR_W'(BLK);
    end
  endtask

  // ---------------- main sequence and final report ----------------
  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      if (c == 2000) rst_armed = 1;
      @(posedge clk);
      #1;
      drive_cycle(c);
      @(negedge clk);
      check_and_model();
    end
    check("reset_mid_wait_hit", 64'(rst_seen), 64'd1);
    check("instr_delivered", 64'(n_pop > 200), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
